rs_issue_select: RTL and testbench
==================================

// Module: rs_issue_select
// PURPOSE
//  Issue stage between the reservation station and the execute FUs. Each cycle it selects up to
//  `N ready RS entries, respecting per-FU-class issue caps, using rotating priority.
//  It reports the selected set back to the RS as rs_data_issuing, then registers the packets
//  into the IS/EX pipeline register. That register tracks branch resolution (b_mask clear/squash).
// PARAMETERS
//  NUM_ALU      3  max ALU-class issues per cycle
//  NUM_MULT     1  max MULT-class issues per cycle (pipelined multiplier)
//  NUM_LDST     1  max LD/ST-class issues per cycle
//  NUM_BR       1  max BRANCH-class issues per cycle
// PORTS
//  clock           in   1                  system clock
//  reset           in   1                  async, active-high
//  rs_data         in   RS_PACKET[`RS_SZ]  RS contents (Source1/2_ready, b_mask, fu_type, ...)
//  rs_valid        in   [`RS_SZ]           RS entry occupied
//  fu_ready        in   [`FU_CLASSES]      FU class can accept an op next cycle
//  ex_ready        in   1                  EX accepts IS/EX register contents this cycle
//  b_mm_resolve    in   B_MASK_MASK        one-hot branch being resolved
//  b_mm_mispred    in   1                  resolving branch mispredicted
//  rs_data_issuing out  [`RS_SZ]           entries leaving RS this cycle (combinational)
//  is_packets      out  ISSUE_PACKET[`N]   registered packets to EX
//  is_valid        out  [`N]               per-slot valid of is_packets
//  num_issued      out  [`NUM_SCALAR_BITS] popcount of rs_data_issuing
// BEHAVIOUR
//  Reset (async): is_valid='0, is_packets='0, prio_ptr=0. Combinational outputs follow from '0 state.
//  Ready(i) = rs_valid[i] & Source1_ready & Source2_ready & fu_ready[class]
//           & !(b_mm_mispred & |(b_mask & b_mm_resolve)).
//  Selection: scan starts at prio_ptr and wraps modulo `RS_SZ.
//   - Take the first ready entries in scan order.
//   - Stop a class at its cap; stop the whole scan at `N total.
//  Slot k of is_packets receives the k-th selected entry in scan order.
//  Unused slots get is_valid=0.
//  Issue enable: when hold=(|is_valid & !ex_ready):
//   - rs_data_issuing='0 and num_issued=0.
//   - The register holds. Exception: the squash/clear rules below still apply to held packets.
//  Otherwise the register loads the new selection (latency 1 cycle RS->EX).
//  prio_ptr: if num_issued>0, next = (index of last selected entry + 1) mod `RS_SZ;
//   otherwise it is unchanged. Wrap from `RS_SZ-1 goes to 0.
//  Branch tracking in IS/EX register, applied every cycle including hold:
//   - b_mm_mispred & |(pkt.b_mask & b_mm_resolve): is_valid cleared.
//   - b_mm_resolve & !b_mm_mispred: matching b_mask bit cleared.
//  Packets loaded this cycle have the same rule applied before they are registered.
//  A registered packet never carries a b_mask bit that was resolved in the prior cycle.
//  Invariants:
//   - num_issued <= `N; per-class count <= cap.
//   - rs_data_issuing is a subset of rs_valid.
//   - No entry is selected twice.
//  Zero ready entries: rs_data_issuing='0, and on a non-hold cycle the register loads all-invalid.
//  Mid-operation reset clears the register immediately; prio_ptr returns to 0.
// STRUCTURE
//  sys_defs.svh: ISSUE_PACKET, FU_TYPE enum, `FU_CLASSES, NUM_*
//   (issue caps live in the package; the parameters default to them).
//  Sub-module rs_rr_select: parameterised wrapped priority selector
//   (req vector, start ptr, cap) -> grant vector. One instance per FU class.
//  A final ordering pass merges the class grants, truncates to `N in scan order, and packs slots.
//  Top level: prio_ptr register, IS/EX register, b_mask update logic.
// TESTING
//  1. All 8 entries ready ALU, N=3, prio_ptr=0 -> issuing=0b00000111, slots=0,1,2; next cycle ptr=3.
//  2. ptr=6, entries 7,0,1 ready ALU -> issue 7,0,1 (wrap); ptr=2.
//  3. Entries 0,1 ready MULT, 2 ready ALU, NUM_MULT=1 -> issue 0 and 2 only; entry 1 next cycle.
//  4. Hold: is_valid=3'b011, ex_ready=0, ready entries present -> issuing='0;
//     register unchanged; then ex_ready=1 -> new load.
//  5. Mispred b_mm_resolve=4'b0010: registered slot b_mask=4'b0010 -> is_valid 0 next cycle;
//     RS entry with that bit not selected.
//  6. Correct resolve 4'b0100 while loading b_mask=4'b0110 -> registered b_mask=4'b0010;
//     async reset mid-hold -> is_valid='0 immediately.

Source files
------------

// File: rtl/rs_issue_select_pkg.sv
// Shared types and sizing for the issue-select stage: RS/issue packet layouts,
// FU classes, default per-class issue caps and branch-mask helpers.
package rs_issue_select_pkg;

    localparam int RS_SZ           = 8;
    localparam int N               = 3;
    localparam int FU_CLASSES      = 4;
    localparam int B_MASK_W        = 4;
    localparam int TAG_W           = 6;
    localparam int RS_IDX_W        = $clog2(RS_SZ);
    localparam int NUM_SCALAR_BITS = $clog2(N + 1);
    localparam int CAP_W           = NUM_SCALAR_BITS;

    localparam int NUM_ALU_DEF  = 3;
    localparam int NUM_MULT_DEF = 1;
    localparam int NUM_LDST_DEF = 1;
    localparam int NUM_BR_DEF   = 1;

    typedef enum logic [1:0] {
        FU_ALU  = 2'd0,
        FU_MULT = 2'd1,
        FU_LDST = 2'd2,
        FU_BR   = 2'd3
    } fu_type_e;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        fu_type_e            fu_type;
        logic [B_MASK_W-1:0] b_mask;
        logic                src1_ready;
        logic                src2_ready;
    } rs_packet_t;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        fu_type_e            fu_type;
        logic [B_MASK_W-1:0] b_mask;
        logic [RS_IDX_W-1:0] rs_idx;
    } issue_packet_t;

    // An op dies when it sits in the shadow of the branch that just mispredicted.
    function automatic logic is_squashed(input logic [B_MASK_W-1:0] b_mask,
                                         input logic [B_MASK_W-1:0] resolve,
                                         input logic                mispred);
        return mispred & (|(b_mask & resolve));
    endfunction

    function automatic logic [B_MASK_W-1:0] clear_resolved(input logic [B_MASK_W-1:0] b_mask,
                                                           input logic [B_MASK_W-1:0] resolve,
                                                           input logic                mispred);
        return mispred ? b_mask : (b_mask & ~resolve);
    endfunction

endpackage

// File: rtl/rs_issue_select_if.sv
// Bundle of RS-side inputs, branch-resolution inputs and issue outputs of rs_issue_select.
interface rs_issue_select_if;
    import rs_issue_select_pkg::*;

    rs_packet_t    [RS_SZ-1:0]      rs_data;
    logic          [RS_SZ-1:0]      rs_valid;
    logic          [FU_CLASSES-1:0] fu_ready;
    logic                           ex_ready;
    logic          [B_MASK_W-1:0]   b_mm_resolve;
    logic                           b_mm_mispred;
    logic          [RS_SZ-1:0]      rs_data_issuing;
    issue_packet_t [N-1:0]          is_packets;
    logic          [N-1:0]          is_valid;
    logic [NUM_SCALAR_BITS-1:0]     num_issued;

    modport master (
        output rs_data, rs_valid, fu_ready, ex_ready, b_mm_resolve, b_mm_mispred,
        input  rs_data_issuing, is_packets, is_valid, num_issued
    );

    modport slave (
        input  rs_data, rs_valid, fu_ready, ex_ready, b_mm_resolve, b_mm_mispred,
        output rs_data_issuing, is_packets, is_valid, num_issued
    );

endinterface

// File: rtl/rs_issue_select_rr_select.sv
// Wrapped priority selector: grants the first `cap` requests found scanning
// upward from `start`, wrapping modulo SZ.
module rs_rr_select #(
    parameter int SZ    = 8,
    parameter int PTR_W = 3,
    parameter int CAP_W = 2
) (
    input  logic [SZ-1:0]    req,
    input  logic [PTR_W-1:0] start,
    input  logic [CAP_W-1:0] cap,
    output logic [SZ-1:0]    grant
);

    int               pos;
    logic [PTR_W-1:0] idx;
    logic [CAP_W-1:0] cnt;

    always_comb begin
        grant = '0;
        pos   = 0;
        idx   = '0;
        cnt   = '0;
        for (int k = 0; k < SZ; k++) begin
            pos = int'(start) + k;
            if (pos >= SZ) pos = pos - SZ;
            idx = PTR_W'(pos);
            if (req[idx] && (cnt < cap)) begin
                grant[idx] = 1'b1;
                cnt        = cnt + CAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/rs_issue_select.sv
// Issue stage: rotating-priority selection of ready RS entries under per-class caps,
// feeding an IS/EX register that tracks branch resolution while it holds.
module rs_issue_select
    import rs_issue_select_pkg::*;
#(
    parameter int NUM_ALU  = NUM_ALU_DEF,
    parameter int NUM_MULT = NUM_MULT_DEF,
    parameter int NUM_LDST = NUM_LDST_DEF,
    parameter int NUM_BR   = NUM_BR_DEF
) (
    input logic              clock,
    input logic              reset,
    rs_issue_select_if.slave io
);

    function automatic logic [CAP_W-1:0] class_cap(input int c);
        case (c)
            0:       return CAP_W'(NUM_ALU);
            1:       return CAP_W'(NUM_MULT);
            2:       return CAP_W'(NUM_LDST);
            default: return CAP_W'(NUM_BR);
        endcase
    endfunction

    logic [RS_SZ-1:0]                  ready;
    logic [FU_CLASSES-1:0][RS_SZ-1:0]  class_req;
    logic [FU_CLASSES-1:0][RS_SZ-1:0]  class_grant;
    logic [RS_SZ-1:0]                  merged;
    logic [RS_SZ-1:0]                  sel_mask;
    logic [N-1:0]                      sel_valid;
    issue_packet_t [N-1:0]             sel_packets;
    logic [RS_IDX_W-1:0]               last_idx;
    logic [NUM_SCALAR_BITS-1:0]        slot;
    int                                ord_pos;
    logic [RS_IDX_W-1:0]               ord_idx;
    logic                              hold;

    logic [RS_IDX_W-1:0]               prio_ptr_q, prio_ptr_d;
    logic [N-1:0]                      is_valid_q, is_valid_d;
    issue_packet_t [N-1:0]             is_packets_q, is_packets_d;

    always_comb begin
        ready     = '0;
        class_req = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            ready[i] = io.rs_valid[i]
                     & io.rs_data[i].src1_ready
                     & io.rs_data[i].src2_ready
                     & io.fu_ready[io.rs_data[i].fu_type]
                     & ~is_squashed(io.rs_data[i].b_mask, io.b_mm_resolve, io.b_mm_mispred);
            for (int c = 0; c < FU_CLASSES; c++) begin
                class_req[c][i] = ready[i] & (int'(io.rs_data[i].fu_type) == c);
            end
        end
    end

    for (genvar c = 0; c < FU_CLASSES; c++) begin : g_class
        rs_rr_select #(
            .SZ    (RS_SZ),
            .PTR_W (RS_IDX_W),
            .CAP_W (CAP_W)
        ) u_sel (
            .req   (class_req[c]),
            .start (prio_ptr_q),
            .cap   (class_cap(c)),
            .grant (class_grant[c])
        );
    end

    // Merge class grants, keep the first N in scan order and pack them into slots.
    always_comb begin
        merged      = '0;
        sel_mask    = '0;
        sel_valid   = '0;
        sel_packets = '0;
        last_idx    = prio_ptr_q;
        slot        = '0;
        ord_pos     = 0;
        ord_idx     = '0;
        for (int c = 0; c < FU_CLASSES; c++) begin
            merged = merged | class_grant[c];
        end
        for (int k = 0; k < RS_SZ; k++) begin
            ord_pos = int'(prio_ptr_q) + k;
            if (ord_pos >= RS_SZ) ord_pos = ord_pos - RS_SZ;
            ord_idx = RS_IDX_W'(ord_pos);
            if (merged[ord_idx] && (slot < NUM_SCALAR_BITS'(N))) begin
                sel_mask[ord_idx]           = 1'b1;
                sel_valid[slot]             = 1'b1;
                sel_packets[slot].tag       = io.rs_data[ord_idx].tag;
                sel_packets[slot].fu_type   = io.rs_data[ord_idx].fu_type;
                sel_packets[slot].b_mask    = io.rs_data[ord_idx].b_mask;
                sel_packets[slot].rs_idx    = ord_idx;
                last_idx                    = ord_idx;
                slot                        = slot + NUM_SCALAR_BITS'(1);
            end
        end
    end

    assign hold               = (|is_valid_q) & ~io.ex_ready;
    assign io.rs_data_issuing = hold ? '0 : sel_mask;
    assign io.num_issued      = NUM_SCALAR_BITS'($countones(io.rs_data_issuing));

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (|io.rs_data_issuing) begin
            prio_ptr_d = (last_idx == RS_IDX_W'(RS_SZ - 1)) ? '0 : last_idx + RS_IDX_W'(1);
        end
    end

    // Branch resolution applies both to held packets and to packets loading now.
    always_comb begin
        is_valid_d   = '0;
        is_packets_d = '0;
        for (int s = 0; s < N; s++) begin
            is_packets_d[s] = hold ? is_packets_q[s] : sel_packets[s];
            is_valid_d[s]   = (hold ? is_valid_q[s] : sel_valid[s])
                            & ~is_squashed(is_packets_d[s].b_mask, io.b_mm_resolve, io.b_mm_mispred);
            is_packets_d[s].b_mask = clear_resolved(is_packets_d[s].b_mask,
                                                    io.b_mm_resolve, io.b_mm_mispred);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_ptr_q   <= '0;
            is_valid_q   <= '0;
            is_packets_q <= '0;
        end else begin
            prio_ptr_q   <= prio_ptr_d;
            is_valid_q   <= is_valid_d;
            is_packets_q <= is_packets_d;
        end
    end

    assign io.is_valid   = is_valid_q;
    assign io.is_packets = is_packets_q;

endmodule

// File: tb/tb_rs_issue_select.sv
// Bench for rs_issue_select: vector table with a packet scoreboard, then hand-written
// hold / branch-resolution / async-reset sequences.
module tb_rs_issue_select;
    import rs_issue_select_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_issue_select_if ifc ();

    rs_issue_select dut (
        .clock (clk),
        .reset (rst),
        .io    (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  valid;
        logic [7:0]  s1;
        logic [7:0]  s2;
        logic [15:0] types;
        logic [31:0] bms;
        logic [3:0]  fu_rdy;
        logic [3:0]  res;
        logic        mis;
        logic [7:0]  exp_iss;
        int          exp_num;
    } vec_t;

    typedef struct packed {
        logic [N-1:0]                v;
        logic [N-1:0][TAG_W-1:0]     tag;
        logic [N-1:0][B_MASK_W-1:0]  bm;
    } exp_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    exp_t sb_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] valid, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [15:0] types, input logic [31:0] bms,
                         input logic [3:0] fu_rdy, input logic ex_rdy,
                         input logic [3:0] res, input logic mis);
        for (int i = 0; i < RS_SZ; i++) begin
            ifc.rs_data[i].tag        = TAG_W'(i + 32);
            ifc.rs_data[i].fu_type    = fu_type_e'(types[2*i +: 2]);
            ifc.rs_data[i].b_mask     = bms[4*i +: 4];
            ifc.rs_data[i].src1_ready = s1[i];
            ifc.rs_data[i].src2_ready = s2[i];
        end
        ifc.rs_valid     = valid;
        ifc.fu_ready     = fu_rdy;
        ifc.ex_ready     = ex_rdy;
        ifc.b_mm_resolve = res;
        ifc.b_mm_mispred = mis;
    endtask

    initial begin
        int   ptr_m;
        int   slot;
        int   last;
        int   idx;
        exp_t e;
        exp_t got;
        logic [3:0] clr;

        //            valid  s1     s2     types     bms           fu    res   mis  iss    num
        vecs[0]  = '{8'hff, 8'hff, 8'hff, 16'h0000, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h07, 3};
        vecs[1]  = '{8'hff, 8'h00, 8'hff, 16'h0000, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h00, 0};
        vecs[2]  = '{8'h38, 8'hff, 8'hff, 16'h0000, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h38, 3};
        vecs[3]  = '{8'h83, 8'hff, 8'hff, 16'h0000, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h83, 3};
        vecs[4]  = '{8'h1c, 8'hff, 8'hff, 16'h0050, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h14, 2};
        vecs[5]  = '{8'h08, 8'hff, 8'hff, 16'h0040, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h08, 1};
        vecs[6]  = '{8'hff, 8'hff, 8'hff, 16'h0000, 32'h0000_0000, 4'he, 4'h0, 1'b0, 8'h00, 0};
        vecs[7]  = '{8'hff, 8'hff, 8'hff, 16'hAF00, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h51, 3};
        vecs[8]  = '{8'h06, 8'hff, 8'hff, 16'h0000, 32'h0000_0420, 4'hf, 4'h2, 1'b1, 8'h04, 1};
        vecs[9]  = '{8'h08, 8'hff, 8'hff, 16'h0000, 32'h0000_6000, 4'hf, 4'h4, 1'b0, 8'h08, 1};
        vecs[10] = '{8'hff, 8'hff, 8'hf0, 16'h0000, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h70, 3};
        vecs[11] = '{8'h00, 8'hff, 8'hff, 16'h0000, 32'h0000_0000, 4'hf, 4'h0, 1'b0, 8'h00, 0};

        drive(8'h00, 8'h00, 8'h00, 16'h0, 32'h0, 4'h0, 1'b1, 4'h0, 1'b0);
        #2;
        chk("reset_is_valid", 64'(ifc.is_valid), 64'h0);
        chk("reset_issuing", 64'(ifc.rs_data_issuing), 64'h0);
        chk("reset_num", 64'(ifc.num_issued), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        ptr_m = 0;
        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            drive(vecs[v].valid, vecs[v].s1, vecs[v].s2, vecs[v].types, vecs[v].bms,
                  vecs[v].fu_rdy, 1'b1, vecs[v].res, vecs[v].mis);
            #1;
            chk($sformatf("v%0d_issuing", v), 64'(ifc.rs_data_issuing), 64'(vecs[v].exp_iss));
            chk($sformatf("v%0d_num", v), 64'(ifc.num_issued), 64'(vecs[v].exp_num));
            e    = '0;
            slot = 0;
            last = ptr_m;
            clr  = vecs[v].mis ? 4'h0 : vecs[v].res;
            for (int k = 0; k < RS_SZ; k++) begin
                idx = (ptr_m + k) % RS_SZ;
                if (vecs[v].exp_iss[idx] && slot < N) begin
                    e.v[slot]   = 1'b1;
                    e.tag[slot] = TAG_W'(idx + 32);
                    e.bm[slot]  = vecs[v].bms[4*idx +: 4] & ~clr;
                    last        = idx;
                    slot++;
                end
            end
            if (vecs[v].exp_iss != 8'h00) ptr_m = (last + 1) % RS_SZ;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL v%0d_scoreboard_empty actual=0 required=1", v);
            end else begin
                e = sb_q.pop_front();
                got.v = ifc.is_valid;
                chk($sformatf("v%0d_is_valid", v), 64'(got.v), 64'(e.v));
                for (int s = 0; s < N; s++) begin
                    if (e.v[s]) begin
                        chk($sformatf("v%0d_slot%0d_tag", v, s), 64'(ifc.is_packets[s].tag), 64'(e.tag[s]));
                        chk($sformatf("v%0d_slot%0d_bmask", v, s), 64'(ifc.is_packets[s].b_mask), 64'(e.bm[s]));
                    end
                end
            end
        end

        // Priority pointer is now 7: entries 0 and 1 issue after wrapping.
        @(negedge clk);
        drive(8'h03, 8'hff, 8'hff, 16'h0, 32'h0000_0012, 4'hf, 1'b1, 4'h0, 1'b0);
        #1;
        chk("h0_issuing", 64'(ifc.rs_data_issuing), 64'h03);
        @(posedge clk); #1;
        chk("h0_is_valid", 64'(ifc.is_valid), 64'h3);

        @(negedge clk);
        drive(8'hff, 8'hff, 8'hff, 16'h0, 32'h0, 4'hf, 1'b0, 4'h0, 1'b0);
        #1;
        chk("h1_hold_issuing", 64'(ifc.rs_data_issuing), 64'h00);
        chk("h1_hold_num", 64'(ifc.num_issued), 64'h0);
        @(posedge clk); #1;
        chk("h1_hold_is_valid", 64'(ifc.is_valid), 64'h3);
        chk("h1_hold_slot0_tag", 64'(ifc.is_packets[0].tag), 64'd32);
        chk("h1_hold_slot1_tag", 64'(ifc.is_packets[1].tag), 64'd33);

        @(negedge clk);
        drive(8'hff, 8'hff, 8'hff, 16'h0, 32'h0, 4'hf, 1'b0, 4'h2, 1'b1);
        #1;
        chk("h2_mispred_issuing", 64'(ifc.rs_data_issuing), 64'h00);
        @(posedge clk); #1;
        chk("h2_mispred_is_valid", 64'(ifc.is_valid), 64'h2);
        chk("h2_slot1_bmask", 64'(ifc.is_packets[1].b_mask), 64'h1);

        @(negedge clk);
        drive(8'hff, 8'hff, 8'hff, 16'h0, 32'h0, 4'hf, 1'b0, 4'h1, 1'b0);
        @(posedge clk); #1;
        chk("h3_resolve_is_valid", 64'(ifc.is_valid), 64'h2);
        chk("h3_resolve_slot1_bmask", 64'(ifc.is_packets[1].b_mask), 64'h0);

        @(negedge clk);
        drive(8'hff, 8'hff, 8'hff, 16'h0, 32'h0, 4'hf, 1'b1, 4'h0, 1'b0);
        #1;
        chk("h4_release_issuing", 64'(ifc.rs_data_issuing), 64'h1c);
        @(posedge clk); #1;
        chk("h4_release_is_valid", 64'(ifc.is_valid), 64'h7);
        chk("h4_slot0_tag", 64'(ifc.is_packets[0].tag), 64'd34);
        chk("h4_slot2_tag", 64'(ifc.is_packets[2].tag), 64'd36);

        // Async reset in the middle of a hold cycle.
        @(negedge clk);
        drive(8'hff, 8'hff, 8'hff, 16'h0, 32'h0, 4'hf, 1'b0, 4'h0, 1'b0);
        #1;
        chk("h5_hold_issuing", 64'(ifc.rs_data_issuing), 64'h00);
        #1;
        rst = 1'b1;
        #1;
        chk("h5_reset_is_valid", 64'(ifc.is_valid), 64'h0);
        chk("h5_reset_ptr_issuing", 64'(ifc.rs_data_issuing), 64'h07);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("h5_after_reset_is_valid", 64'(ifc.is_valid), 64'h7);
        chk("h5_after_reset_slot0_tag", 64'(ifc.is_packets[0].tag), 64'd32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
